// File: rtl/pc_sequencer.sv
// Program-counter sequencer with configurable step and reset vector.
// Supports stall, relative/absolute/call/return branches, halt/resume and a terminal fault state.
module pc_sequencer #(
    parameter int              PC_W        = 16,
    parameter int              STEP        = 1,
    parameter logic [PC_W-1:0] RESET_VEC   = '0,
    parameter int              STACK_DEPTH = 4
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             stall,
    input  logic                             branch_valid,
    input  logic [1:0]                       branch_mode,
    input  logic [PC_W-1:0]                  branch_target,
    input  logic                             halt_req,
    input  logic                             resume,
    output logic [PC_W-1:0]                  pc,
    output logic                             pc_valid,
    output logic [1:0]                       state,
    output logic [$clog2(STACK_DEPTH+1)-1:0] stack_depth,
    output logic                             stack_ovf,
    output logic                             stack_unf
);

    localparam int              DW     = $clog2(STACK_DEPTH + 1);
    localparam int              AW     = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam logic [PC_W-1:0] STEP_V = PC_W'(STEP);
    localparam logic [DW-1:0]   FULL_V = DW'(STACK_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_HALT  = 2'b10,
        ST_FAULT = 2'b11
    } state_t;

    state_t            state_r, state_nx_s;
    logic [PC_W-1:0]   pc_r, pc_nx_s, pc_inc_s, top_s;
    logic [DW-1:0]     depth_r, depth_nx_s;
    logic              ovf_r, ovf_nx_s, unf_r, unf_nx_s;
    logic              pc_valid_r, push_s;
    logic [AW-1:0]     wr_idx_s, rd_idx_s;
    logic [PC_W-1:0]   stack_r [STACK_DEPTH];

    // Entry at index depth-1 is the top of the return stack.
    assign pc_inc_s = pc_r + STEP_V;
    assign wr_idx_s = depth_r[AW-1:0];
    assign rd_idx_s = wr_idx_s - AW'(1'b1);
    assign top_s    = stack_r[rd_idx_s];

    // Next-state, next-pc and stack control for the sequencer FSM.
    always_comb begin
        state_nx_s = state_r;
        pc_nx_s    = pc_r;
        depth_nx_s = depth_r;
        ovf_nx_s   = ovf_r;
        unf_nx_s   = unf_r;
        push_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                state_nx_s = ST_RUN;
            end
            ST_RUN: begin
                if (halt_req) begin
                    state_nx_s = ST_HALT;
                end else if (stall) begin
                    pc_nx_s = pc_r;
                end else if (branch_valid) begin
                    case (branch_mode)
                        2'b00: pc_nx_s = pc_r + branch_target;
                        2'b01: pc_nx_s = branch_target;
                        2'b10: begin
                            if (depth_r == FULL_V) begin
                                ovf_nx_s   = 1'b1;
                                state_nx_s = ST_FAULT;
                            end else begin
                                push_s     = 1'b1;
                                depth_nx_s = depth_r + DW'(1'b1);
                                pc_nx_s    = branch_target;
                            end
                        end
                        2'b11: begin
                            if (depth_r == {DW{1'b0}}) begin
                                unf_nx_s   = 1'b1;
                                state_nx_s = ST_FAULT;
                            end else begin
                                depth_nx_s = depth_r - DW'(1'b1);
                                pc_nx_s    = top_s;
                            end
                        end
                        default: pc_nx_s = pc_r;
                    endcase
                end else begin
                    pc_nx_s = pc_inc_s;
                end
            end
            ST_HALT: begin
                if (resume && !halt_req) begin
                    state_nx_s = ST_RUN;
                end else begin
                    state_nx_s = ST_HALT;
                end
            end
            ST_FAULT: begin
                state_nx_s = ST_FAULT;
            end
            default: begin
                state_nx_s = ST_FAULT;
            end
        endcase
    end

    // Architectural state registers; reset aborts any operation immediately.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r    <= ST_IDLE;
            pc_r       <= RESET_VEC;
            depth_r    <= {DW{1'b0}};
            ovf_r      <= 1'b0;
            unf_r      <= 1'b0;
            pc_valid_r <= 1'b0;
        end else begin
            state_r    <= state_nx_s;
            pc_r       <= pc_nx_s;
            depth_r    <= depth_nx_s;
            ovf_r      <= ovf_nx_s;
            unf_r      <= unf_nx_s;
            pc_valid_r <= (state_nx_s == ST_RUN);
        end
    end

    // Return-stack storage; contents are cleared on reset so no X can reach pc.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < STACK_DEPTH; i++) begin
                stack_r[i] <= {PC_W{1'b0}};
            end
        end else if (push_s) begin
            stack_r[wr_idx_s] <= pc_inc_s;
        end else begin
            stack_r[wr_idx_s] <= stack_r[wr_idx_s];
        end
    end

    assign pc          = pc_r;
    assign pc_valid    = pc_valid_r;
    assign state       = state_r;
    assign stack_depth = depth_r;
    assign stack_ovf   = ovf_r;
    assign stack_unf   = unf_r;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed test-plan steps followed by
// randomized traffic, all compared against a queue-based behavioural model.
module tb_pc_sequencer;

    localparam int          PC_W  = 16;
    localparam int          DEPTH = 4;
    localparam logic [15:0] RVEC  = 16'h0100;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        branch_valid;
    logic [1:0]  branch_mode;
    logic [15:0] branch_target;
    logic        halt_req;
    logic        resume;
    logic [15:0] pc;
    logic        pc_valid;
    logic [1:0]  state;
    logic [2:0]  stack_depth;
    logic        stack_ovf;
    logic        stack_unf;

    pc_sequencer #(
        .PC_W       (PC_W),
        .STEP       (1),
        .RESET_VEC  (RVEC),
        .STACK_DEPTH(DEPTH)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .stall        (stall),
        .branch_valid (branch_valid),
        .branch_mode  (branch_mode),
        .branch_target(branch_target),
        .halt_req     (halt_req),
        .resume       (resume),
        .pc           (pc),
        .pc_valid     (pc_valid),
        .state        (state),
        .stack_depth  (stack_depth),
        .stack_ovf    (stack_ovf),
        .stack_unf    (stack_unf)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    int checks = 0;
    int errors = 0;

    // Reference model: 0 idle, 1 run, 2 halt, 3 fault.
    int          m_state;
    logic [15:0] m_pc;
    logic [15:0] m_stack [$];
    bit          m_ovf;
    bit          m_unf;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".pc"},       pc,          m_pc);
        chk({tag, ".state"},    state,       m_state);
        chk({tag, ".pc_valid"}, pc_valid,    (m_state == 1));
        chk({tag, ".depth"},    stack_depth, m_stack.size());
        chk({tag, ".ovf"},      stack_ovf,   m_ovf);
        chk({tag, ".unf"},      stack_unf,   m_unf);
    endtask

    task automatic model_step(input bit h, input bit r, input bit s, input bit bv,
                              input logic [1:0] md, input logic [15:0] tg);
        case (m_state)
            0: m_state = 1;
            1: begin
                if (h) m_state = 2;
                else if (s) m_state = 1;
                else if (bv) begin
                    case (md)
                        2'd0: m_pc = m_pc + tg;
                        2'd1: m_pc = tg;
                        2'd2: begin
                            if (m_stack.size() == DEPTH) begin
                                m_ovf = 1'b1; m_state = 3;
                            end else begin
                                m_stack.push_back(m_pc + 16'd1);
                                m_pc = tg;
                            end
                        end
                        default: begin
                            if (m_stack.size() == 0) begin
                                m_unf = 1'b1; m_state = 3;
                            end else begin
                                m_pc = m_stack.pop_back();
                            end
                        end
                    endcase
                end else m_pc = m_pc + 16'd1;
            end
            2: if (r && !h) m_state = 1;
            default: m_state = 3;
        endcase
    endtask

    task automatic cycle(input string tag, input bit h, input bit r, input bit s, input bit bv,
                         input logic [1:0] md, input logic [15:0] tg);
        halt_req = h; resume = r; stall = s; branch_valid = bv;
        branch_mode = md; branch_target = tg;
        model_step(h, r, s, bv, md, tg);
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b0;
        m_state = 0; m_pc = RVEC; m_stack.delete(); m_ovf = 1'b0; m_unf = 1'b0;
        #2;
        check_all({tag, ".async"});
        @(posedge clk);
        #1;
        check_all({tag, ".held"});
        reset = 1'b1;
    endtask

    initial begin
        reset = 1'b0; stall = 1'b0; branch_valid = 1'b0; branch_mode = 2'b00;
        branch_target = 16'h0000; halt_req = 1'b0; resume = 1'b0;
        #7;

        // 1: reset vector becomes first fetch address, then sequential advance
        do_reset("rst1");
        cycle("t1.e1", 0, 0, 0, 0, 2'b00, 16'h0000);
        cycle("t1.e2", 0, 0, 0, 0, 2'b00, 16'h0000);
        cycle("t1.e3", 0, 0, 0, 0, 2'b00, 16'h0000);
        chk("t1.anchor", pc, 16'h0102);

        // 2: relative backwards, absolute, wrap
        cycle("t2.abs10", 0, 0, 0, 1, 2'b01, 16'h0010);
        cycle("t2.rel",   0, 0, 0, 1, 2'b00, 16'hFFFC);
        chk("t2.rel_anchor", pc, 16'h000C);
        cycle("t2.abs",   0, 0, 0, 1, 2'b01, 16'h4000);
        cycle("t2.absff", 0, 0, 0, 1, 2'b01, 16'hFFFF);
        cycle("t2.wrap",  0, 0, 0, 0, 2'b00, 16'h0000);
        chk("t2.wrap_anchor", pc, 16'h0000);

        // 3: fill the stack with calls, unwind, then underflow into FAULT
        cycle("t3.abs", 0, 0, 0, 1, 2'b01, 16'h0010);
        for (int i = 1; i <= 4; i++) cycle("t3.call", 0, 0, 0, 1, 2'b10, 16'((i + 1) * 16));
        chk("t3.depth_anchor", stack_depth, 3'd4);
        for (int i = 0; i < 4; i++) cycle("t3.ret", 0, 0, 0, 1, 2'b11, 16'h0000);
        chk("t3.ret_anchor", pc, 16'h0011);
        cycle("t3.unf",    0, 0, 0, 1, 2'b11, 16'h0000);
        chk("t3.unf_anchor", {stack_unf, state}, 3'b111);
        cycle("t3.frozen", 0, 1, 0, 1, 2'b01, 16'h1234);

        // 4: overflow into FAULT, frozen, reset clears flags
        do_reset("rst4");
        cycle("t4.idle", 0, 0, 0, 0, 2'b00, 16'h0000);
        for (int i = 0; i < 4; i++) cycle("t4.call", 0, 0, 0, 1, 2'b10, 16'h0800 + 16'(i));
        cycle("t4.ovf",  0, 0, 0, 1, 2'b10, 16'h0900);
        chk("t4.ovf_anchor", {stack_ovf, state}, 3'b111);
        cycle("t4.frz1", 0, 1, 0, 1, 2'b11, 16'h0000);
        cycle("t4.frz2", 0, 0, 0, 1, 2'b01, 16'h5555);
        do_reset("rst4b");

        // 5: stall drops concurrent branch until released
        cycle("t5.idle", 0, 0, 0, 0, 2'b00, 16'h0000);
        for (int i = 0; i < 3; i++) cycle("t5.stall", 0, 0, 1, 1, 2'b01, 16'h0200);
        cycle("t5.go", 0, 0, 0, 1, 2'b01, 16'h0200);
        chk("t5.anchor", pc, 16'h0200);

        // 6: halt beats call, branches ignored in HALT, resume restarts
        cycle("t6.call",  0, 0, 0, 1, 2'b10, 16'h0300);
        cycle("t6.halt",  1, 0, 0, 1, 2'b10, 16'h0400);
        cycle("t6.hbr",   0, 0, 0, 1, 2'b01, 16'h7777);
        cycle("t6.both",  1, 1, 0, 0, 2'b00, 16'h0000);
        cycle("t6.res",   0, 1, 0, 0, 2'b00, 16'h0000);
        cycle("t6.adv",   0, 0, 0, 0, 2'b00, 16'h0000);

        // randomized traffic with occasional reset
        for (int n = 0; n < 600; n++) begin
            if (($urandom_range(0, 99) < 2) || (m_state == 3 && $urandom_range(0, 3) == 0)) begin
                do_reset("rnd.rst");
            end else begin
                cycle("rnd",
                      ($urandom_range(0, 15) == 0),
                      ($urandom_range(0, 3) == 0),
                      ($urandom_range(0, 7) == 0),
                      ($urandom_range(0, 1) == 1),
                      2'($urandom_range(0, 3)),
                      16'($urandom));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Parametrised program-counter sequencer; successor to the free-running 16-bit PC in the processor top level. It adds a configurable width and step, a reset vector, stall, and branch modes: relative, absolute, call and return. Calls and returns use a bounded hardware return stack. It also provides halt/resume and a sticky fault state. Sits between the top level and the fetch unit; drives the fetch address.

Parameters:
PC_W, 16, PC and branch-target width in bits
STEP, 1, increment applied per sequential advance
RESET_VEC, 0, PC value loaded by reset
STACK_DEPTH, 4, return-stack entries (>=1)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset (asserted when 0)
stall  input  1  hold PC this cycle (RUN only)
branch_valid  input  1  branch request this cycle
branch_mode  input  2  00 relative, 01 absolute, 10 call, 11 return
branch_target  input  PC_W  signed offset (relative) or absolute address (absolute/call); ignored for return
halt_req  input  1  enter HALT
resume  input  1  leave HALT
pc  output  PC_W  current fetch address
pc_valid  output  1  pc is a live fetch address
state  output  2  00 IDLE, 01 RUN, 10 HALT, 11 FAULT
stack_depth  output  $clog2(STACK_DEPTH+1)  return-stack occupancy
stack_ovf  output  1  sticky: call attempted with stack full
stack_unf  output  1  sticky: return attempted with stack empty

Behaviour:
- Reset (reset=0, asynchronous):
  - pc=RESET_VEC, state=IDLE, pc_valid=0, stack_depth=0, stack_ovf=0, stack_unf=0.
  - Stack contents don't-care.
  - Reset mid-operation aborts everything immediately.
- pc_valid = (state==RUN), decoded from the state register only; no input-to-output combinational path.
- IDLE: first rising edge after reset release -> RUN, pc unchanged. RESET_VEC is therefore the first valid fetch address. All inputs are ignored in IDLE.
- RUN: per-cycle priority is halt_req > stall > branch_valid > sequential advance.
  - halt_req=1: state->HALT; pc holds; stack unchanged.
  - stall=1: pc and stack hold. A concurrent branch is dropped; the requester must hold branch_valid until not stalled.
  - branch mode 00 (relative): pc <= pc + branch_target, target treated as signed PC_W two's complement, result mod 2^PC_W.
  - branch mode 01 (absolute): pc <= branch_target.
  - branch mode 10 (call):
    - Stack not full: push (pc+STEP) mod 2^PC_W, depth+1, pc <= branch_target.
    - Stack full (depth==STACK_DEPTH): no push, pc holds, stack_ovf<=1, state->FAULT.
  - branch mode 11 (return):
    - Stack not empty: pc <= top entry, depth-1.
    - Stack empty: pc holds, stack_unf<=1, state->FAULT.
  - No branch: pc <= (pc+STEP) mod 2^PC_W, wrapping silently at 2^PC_W.
- HALT: pc, stack and sticky flags hold; stall, branch and halt_req are ignored. resume=1 -> RUN next edge, pc unchanged. halt_req and resume both high: stays HALT.
- FAULT: terminal. pc, stack and flags frozen; all inputs ignored; exit only via reset.
- Stack is LIFO, one push or pop per cycle at most.
- Single-cycle latency: request sampled at edge N gives the new pc visible after edge N.

Test Plan:
1. Reset low then release, PC_W=16, RESET_VEC=0x0100, no requests -> state IDLE, pc=0x0100, pc_valid=0 during reset. After edge 1: RUN, pc=0x0100, pc_valid=1. Edges 2,3: pc=0x0101, 0x0102.
2. pc=0x0010, relative branch with target=0xFFFC -> pc=0x000C. Absolute branch to 0x4000 -> pc=0x4000. pc=0xFFFF, no branch -> pc=0x0000 (wrap).
3. STACK_DEPTH=4, calls at pc=0x10,0x20,0x30,0x40 to targets 0x20,0x30,0x40,0x50 -> depth 4. Four returns -> pc=0x41,0x31,0x21,0x11, depth 0. A fifth return -> stack_unf=1, state=FAULT, pc=0x11 frozen.
4. Depth 4, call -> stack_ovf=1, FAULT, pc unchanged. Further branches and resume have no effect. Reset low -> IDLE, flags cleared.
5. stall=1 with branch_valid=1 (absolute 0x0200) for 3 cycles -> pc holds. stall drops with branch still high -> pc=0x0200 next edge.
6. halt_req together with call -> HALT, pc and depth unchanged, pc_valid=0. Branches during HALT are ignored. resume -> RUN, pc unchanged, pc_valid=1, then sequential advance.
